// File: rtl/seg7_count_display_pkg.sv
// Shared types and constants for the 4-digit seven-segment count display.
// Pure definitions, no latency.
// No flow control; consumers use these constants combinationally.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH
   } state_t;

   localparam int NUM_DIGITS = 4;

   // Segment patterns are {g,f,e,d,c,b,a}, active low
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   // Non-decimal nibbles never reach the display in normal use; show a dash if they do
   function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_DASH;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seg7_count_display_if.sv
// Bundles the count input and the display-side outputs of the seven-segment block.
// Wires only, no latency.
// No handshake: value is sampled whenever the converter is idle.
interface seg7_count_display_if;
   logic [15:0] value;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        busy;
   logic        ovf;

   modport master (output value, input an, seg, dp, busy, ovf);
   modport slave  (input value, output an, seg, dp, busy, ovf);
endinterface

// File: rtl/seg7_count_display_bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 5 BCD nibbles.
// 1 load + 16 shift + 1 latch cycle; done pulses in the latch cycle.
// start is only honoured while idle (busy low); callers hold it until accepted.
module bin2bcd_seq
   import seg7_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] value,
   output logic [19:0] bcd,
   output logic        busy,
   output logic        done
);

   state_t      state_q, state_d;
   logic [15:0] bin_q, bin_d;
   logic [19:0] bcd_q, bcd_d;
   logic [19:0] bcd_adj;
   logic [3:0]  iter_q, iter_d;
   logic        busy_q, busy_d;

   // State and datapath registers; reset abandons any conversion in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         iter_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         busy_q  <= busy_d;
      end
   end

   // Next state: add-3 correction on every nibble >= 5, then shift {bcd,bin} left
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      busy_d  = busy_q;
      bcd_adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d   = value;
               bcd_d   = '0;
               iter_d  = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            iter_d         = iter_q + 4'd1;
            if (iter_q == 4'd15) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign bcd  = bcd_q;
   assign busy = busy_q;
   assign done = (state_q == LATCH);

endmodule

// File: rtl/seg7_count_display.sv
// Converts a 16-bit count to decimal and scans it onto a 4-digit common-anode display.
// Display regs update 18 clk after a value change; scan output an is registered, seg follows it combinationally.
// Value changes during a conversion are caught by the idle compare afterwards; only superseded values are skipped.
module seg7_count_display
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_LZ    = 1
) (
   input logic                clk,
   input logic                rst,
   seg7_count_display_if.slave bus
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [15:0]   last_value;
   logic          pending;
   logic          start;
   logic [19:0]   bcd;
   logic          conv_busy;
   logic          conv_done;
   logic [3:0]    disp [NUM_DIGITS];
   logic          ovf_q;
   logic [CW-1:0] refresh_cnt;
   logic [1:0]    idx;
   logic [3:0]    an_q;
   logic [3:0]    lead_zero;
   logic [6:0]    seg_sel;

   // A new conversion is wanted after reset or whenever the count moved
   assign start = pending || (bus.value != last_value);

   bin2bcd_seq u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .value (bus.value),
      .bcd   (bcd),
      .busy  (conv_busy),
      .done  (conv_done)
   );

   // Remember the value handed to the converter so later changes are noticed
   always_ff @(posedge clk) begin
      if (rst) begin
         last_value <= '0;
         pending    <= 1'b1;
      end else if (start && !conv_busy) begin
         last_value <= bus.value;
         pending    <= 1'b0;
      end
   end

   // Display registers change only when a conversion completes
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         for (int k = 0; k < NUM_DIGITS; k++) begin
            disp[k] <= '0;
         end
      end else if (conv_done) begin
         ovf_q <= (bcd[19:16] != 4'd0);
         for (int k = 0; k < NUM_DIGITS; k++) begin
            disp[k] <= bcd[4*k +: 4];
         end
      end
   end

   // Free-running digit scan, advancing one digit each REFRESH_DIV cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         idx         <= '0;
         an_q        <= 4'b1111;
      end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
         refresh_cnt <= '0;
         idx         <= idx + 2'd1;
         an_q        <= ~(4'b0001 << (idx + 2'd1));
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
         an_q        <= ~(4'b0001 << idx);
      end
   end

   // Pattern for the lit digit: dash on overflow, blank for leading zeros above the units
   always_comb begin
      seg_sel      = SEG_BLANK;
      lead_zero    = 4'b0000;
      lead_zero[3] = (disp[3] == 4'd0);
      lead_zero[2] = lead_zero[3] && (disp[2] == 4'd0);
      lead_zero[1] = lead_zero[2] && (disp[1] == 4'd0);
      if (an_q == 4'b1111) begin
         seg_sel = SEG_BLANK;
      end else if (ovf_q) begin
         seg_sel = SEG_DASH;
      end else if ((BLANK_LZ != 0) && lead_zero[idx]) begin
         seg_sel = SEG_BLANK;
      end else begin
         seg_sel = nibble_to_seg(disp[idx]);
      end
   end

   assign bus.an   = an_q;
   assign bus.seg  = seg_sel;
   assign bus.dp   = 1'b1;
   assign bus.busy = conv_busy;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_seg7_count_display.sv
// Bench for seg7_count_display: directed scenarios plus random counts.
// Expected display values are queued at stimulus time and popped on each conversion completion.
// Scan, segment, blanking and overflow outputs are compared on every falling clock edge.
module tb_seg7_count_display;

   localparam int RDIV = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   seg7_count_display_if bus ();

   seg7_count_display #(.REFRESH_DIV(RDIV), .BLANK_LZ(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];
   int model_last;
   int k        = 0;
   int cyc      = 0;
   int disp_val = 0;
   int rise_cyc = 0;
   int exp_idx;
   int blen;
   logic prev_busy = 1'b0;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
      end
   endtask

   function automatic logic [6:0] digit_pat(input int d);
      logic [6:0] p;
      case (d)
         0: p = 7'h40;  1: p = 7'h79;  2: p = 7'h24;  3: p = 7'h30;  4: p = 7'h19;
         5: p = 7'h12;  6: p = 7'h02;  7: p = 7'h78;  8: p = 7'h00;  default: p = 7'h10;
      endcase
      return p;
   endfunction

   // Expected pattern of decimal position pos (0 = units) when showing v
   function automatic logic [6:0] model_seg(input int v, input int pos);
      int pw = 1;
      for (int i = 0; i < pos; i++) pw = pw * 10;
      if (v > 9999) return 7'h3F;
      if (pos > 0 && v < pw) return 7'h7F;
      return digit_pat((v / pw) % 10);
   endfunction

   // Cycle count since reset release; reset returns the shown value to 0
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         k        = 0;
         disp_val = 0;
      end else begin
         k++;
      end
   end

   // Monitor: pop the scoreboard on each completed conversion and check the scan every cycle
   always @(negedge clk) begin
      if (k == 0) begin
         check("rst_an", bus.an, 4'hF);
         check("rst_seg", bus.seg, 7'h7F);
         check("rst_busy", bus.busy, 0);
         check("rst_ovf", bus.ovf, 0);
      end else begin
         if (!prev_busy && bus.busy) rise_cyc = cyc;
         if (prev_busy && !bus.busy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_conversion", 1, 0);
            end else begin
               disp_val = exp_q.pop_front();
               blen = cyc - rise_cyc;
               n_checks++;
               if (blen < 16 || blen > 18) begin
                  n_fail++;
                  $display("FAIL busy_len: got %0d cycles, expected 16..18", blen);
               end
            end
         end
         exp_idx = (k / RDIV) % 4;
         check("an", bus.an, ~(4'b0001 << exp_idx) & 4'hF);
         check("seg", bus.seg, model_seg(disp_val, exp_idx));
         check("ovf", bus.ovf, (disp_val > 9999) ? 1 : 0);
         check("dp", bus.dp, 1);
      end
      prev_busy = bus.busy;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Apply a count while the converter is idle; a different value yields one conversion
   task automatic set_val(input int v);
      bus.value = 16'(v);
      if (v != model_last) begin
         exp_q.push_back(v);
         model_last = v;
      end
   endtask

   initial begin
      int v;
      bus.value  = '0;
      model_last = 0;
      rst        = 1'b1;
      tick(3);
      rst = 1'b0;
      exp_q.push_back(0);
      tick(30);

      set_val(1234);
      tick(40);

      set_val(10000);
      tick(40);
      set_val(9999);
      tick(40);

      // change lands mid-conversion: both values complete in order
      set_val(5);
      tick(2);
      bus.value = 16'd42;
      exp_q.push_back(42);
      model_last = 42;
      tick(60);

      // reset mid-shift aborts; the pending flag re-converts the same value
      set_val(777);
      tick(3);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(40);

      set_val(65535);
      tick(40);
      set_val(0);
      tick(40);

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(0, 65535));
            1:       v = int'($urandom_range(0, 99));
            default: v = int'($urandom_range(0, 12000));
         endcase
         set_val(v);
         tick(20 + int'($urandom_range(0, 12)));
      end

      tick(40);
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
